stonyman_seq: RTL and testbench

- Frame-capture sequencer for the Stonyman 112x112 vision chip. It is the producer end of the pixel FIFO and the responder to the active-low START_CAPTURE strobe from the APB register block.
- On a capture request it walks every pixel:
  - steers the chip row/column registers via RESP/INCP/RESV/INCV pulses,
  - runs one external ADC conversion per pixel,
  - pushes each 8-bit sample into the FIFO with an active-low write enable.
- It reports BUSY for the whole frame.

---
 rtl/stonyman_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_stonyman_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stonyman_seq.sv
// stonyman_seq: frame-capture sequencer for the Stonyman 112x112 vision chip.
// On a START_CAPTURE strobe it walks every pixel in row-major order. It steers
// the chip pointer/value registers with RESP/INCP/RESV/INCV pulses, runs one
// external ADC conversion per pixel and pushes each sample into the pixel FIFO.
module stonyman_seq #(
    parameter int unsigned ROWS          = 112,
    parameter int unsigned COLS          = 112,
    parameter int unsigned PULSE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic       START_CAPTURE,
    output logic       BUSY,
    output logic       RESP,
    output logic       INCP,
    output logic       RESV,
    output logic       INCV,
    output logic       ADC_START,
    input  logic       ADC_DONE,
    input  logic [7:0] ADC_DATA,
    input  logic       FIFO_FULL,
    output logic       FIFO_WREN,
    output logic [7:0] FIFO_DATA
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ROW_RESP = 4'd1;
    localparam logic [3:0] S_ROW_INCP = 4'd2;
    localparam logic [3:0] S_ROW_RESV = 4'd3;
    localparam logic [3:0] S_ROW_INCV = 4'd4;
    localparam logic [3:0] S_COL_RESP = 4'd5;
    localparam logic [3:0] S_COL_RESV = 4'd6;
    localparam logic [3:0] S_SETTLE   = 4'd7;
    localparam logic [3:0] S_CONV     = 4'd8;
    localparam logic [3:0] S_WAITDONE = 4'd9;
    localparam logic [3:0] S_PUSH     = 4'd10;
    localparam logic [3:0] S_COL_INCV = 4'd11;

    localparam logic [15:0] PULSE_HI    = 16'(PULSE_CYCLES);
    localparam logic [15:0] PULSE_LAST  = 16'(2 * PULSE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [6:0]  ROW_LAST    = 7'(ROWS - 1);
    localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);

    logic [3:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  r_q, r_d;
    logic [6:0]  c_q, c_d;
    logic [6:0]  incv_cnt_q, incv_cnt_d;
    logic        busy_q, busy_d;
    logic        resp_q, resp_d;
    logic        incp_q, incp_d;
    logic        resv_q, resv_d;
    logic        incv_q, incv_d;
    logic        adc_start_q, adc_start_d;
    logic        fifo_wren_q, fifo_wren_d;
    logic [7:0]  fifo_data_q, fifo_data_d;

    logic        pulse_end;
    logic        pulse_hi;
    logic [15:0] cnt_inc;

    // Next-state logic. Outputs are decoded from the next state so every pin
    // is a flop that lines up exactly with the state it belongs to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        c_d         = c_q;
        incv_cnt_d  = incv_cnt_q;
        fifo_data_d = fifo_data_q;
        pulse_end   = (cnt_q == PULSE_LAST);
        cnt_inc     = cnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!START_CAPTURE) begin
                    r_d     = '0;
                    state_d = S_ROW_RESP;
                end
            end
            S_ROW_RESP: begin
                if (pulse_end) begin
                    cnt_d   = '0;
                    state_d = S_ROW_INCP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ROW_INCP: begin
                if (pulse_end) begin
                    cnt_d   = '0;
                    state_d = S_ROW_RESV;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ROW_RESV: begin
                if (pulse_end) begin
                    cnt_d      = '0;
                    incv_cnt_d = '0;
                    state_d    = S_ROW_INCV;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ROW_INCV: begin
                // The row-select test happens at the start of each pulse slot,
                // so row 0 spends one idle cycle here and emits no INCV.
                if (cnt_q == '0 && incv_cnt_q == r_q) begin
                    state_d = S_COL_RESP;
                end else if (pulse_end) begin
                    cnt_d      = '0;
                    incv_cnt_d = incv_cnt_q + 7'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_COL_RESP: begin
                if (pulse_end) begin
                    cnt_d   = '0;
                    state_d = S_COL_RESV;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_COL_RESV: begin
                if (pulse_end) begin
                    cnt_d   = '0;
                    c_d     = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CONV;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_CONV: begin
                cnt_d   = '0;
                state_d = S_WAITDONE;
            end
            S_WAITDONE: begin
                if (ADC_DONE) begin
                    fifo_data_d = ADC_DATA;
                    cnt_d       = '0;
                    state_d     = S_PUSH;
                end
            end
            S_PUSH: begin
                // cnt 0: wait for room; cnt 1: the single write cycle.
                if (cnt_q == '0) begin
                    if (!FIFO_FULL) begin
                        cnt_d = 16'd1;
                    end
                end else begin
                    cnt_d = '0;
                    if (c_q < COL_LAST) begin
                        state_d = S_COL_INCV;
                    end else if (r_q < ROW_LAST) begin
                        r_d     = r_q + 7'd1;
                        state_d = S_ROW_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_COL_INCV: begin
                if (pulse_end) begin
                    cnt_d   = '0;
                    c_d     = c_q + 7'd1;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        pulse_hi    = (cnt_d < PULSE_HI);
        busy_d      = (state_d != S_IDLE);
        resp_d      = (state_d == S_ROW_RESP || state_d == S_COL_RESP) && pulse_hi;
        incp_d      = (state_d == S_ROW_INCP) && pulse_hi;
        resv_d      = (state_d == S_ROW_RESV || state_d == S_COL_RESV) && pulse_hi;
        incv_d      = ((state_d == S_ROW_INCV && incv_cnt_d != r_d) ||
                       state_d == S_COL_INCV) && pulse_hi;
        adc_start_d = (state_d == S_CONV);
        fifo_wren_d = !(state_d == S_PUSH && cnt_d == 16'd1);
    end

    // State, counters and registered outputs; reset aborts any frame at once.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            c_q         <= '0;
            incv_cnt_q  <= '0;
            busy_q      <= 1'b0;
            resp_q      <= 1'b0;
            incp_q      <= 1'b0;
            resv_q      <= 1'b0;
            incv_q      <= 1'b0;
            adc_start_q <= 1'b0;
            fifo_wren_q <= 1'b1;
            fifo_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            c_q         <= c_d;
            incv_cnt_q  <= incv_cnt_d;
            busy_q      <= busy_d;
            resp_q      <= resp_d;
            incp_q      <= incp_d;
            resv_q      <= resv_d;
            incv_q      <= incv_d;
            adc_start_q <= adc_start_d;
            fifo_wren_q <= fifo_wren_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign BUSY      = busy_q;
    assign RESP      = resp_q;
    assign INCP      = incp_q;
    assign RESV      = resv_q;
    assign INCV      = incv_q;
    assign ADC_START = adc_start_q;
    assign FIFO_WREN = fifo_wren_q;
    assign FIFO_DATA = fifo_data_q;

endmodule

// File: tb/tb_stonyman_seq.sv
// Bench for stonyman_seq on a 2x3 frame. An ADC model delivers samples and
// queues them as the expected FIFO stream; a monitor pops and compares every
// FIFO write and checks pulse shapes, ADC timing and per-frame totals.
module tb_stonyman_seq;

    localparam int R = 2;
    localparam int C = 3;
    localparam int P = 2;
    localparam int S = 3;

    logic       PCLK, PRESERN, START_CAPTURE;
    logic       BUSY, RESP, INCP, RESV, INCV, ADC_START;
    logic       ADC_DONE, FIFO_FULL, FIFO_WREN;
    logic [7:0] ADC_DATA, FIFO_DATA;

    stonyman_seq #(.ROWS(R), .COLS(C), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .START_CAPTURE(START_CAPTURE),
        .BUSY(BUSY), .RESP(RESP), .INCP(INCP), .RESV(RESV), .INCV(INCV),
        .ADC_START(ADC_START), .ADC_DONE(ADC_DONE), .ADC_DATA(ADC_DATA),
        .FIFO_FULL(FIFO_FULL), .FIFO_WREN(FIFO_WREN), .FIFO_DATA(FIFO_DATA)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // shared state between stimulus, ADC model and monitor
    logic [7:0] exp_q[$];
    bit rand_data = 0, rand_full = 0, bp_mode = 0, bp_done = 0;
    int frames_done = 0, act_cnt = 0;
    int n_wr = 0, n_adc = 0;

    // ADC and FIFO-full model: reply to each ADC_START and record the sample
    initial begin : adc_model
        int cd, hold, full_cnt, n;
        logic [7:0] val;
        ADC_DONE = 0; ADC_DATA = 0; FIFO_FULL = 0;
        cd = 0; hold = 0; full_cnt = 0; n = 0;
        forever begin
            @(posedge PCLK); #1;
            if (!PRESERN) begin
                ADC_DONE = 0; FIFO_FULL = 0; cd = 0; hold = 0; full_cnt = 0; n = 0;
            end else begin
                if (!BUSY) n = 0;
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) ADC_DONE = 0;
                end
                if (full_cnt > 0) begin
                    full_cnt--;
                    if (full_cnt == 0) FIFO_FULL = 0;
                end else if (rand_full) begin
                    FIFO_FULL = ($urandom_range(0, 3) == 0);
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        val = rand_data ? 8'($urandom) : 8'(8'h10 + n);
                        ADC_DATA = val;
                        ADC_DONE = 1;
                        exp_q.push_back(val);
                        hold = rand_data ? $urandom_range(1, 3) : 1;
                        if (bp_mode && n == 2) begin
                            FIFO_FULL = 1;
                            full_cnt = 20;
                        end
                        n++;
                    end
                end
                if (ADC_START) cd = rand_data ? $urandom_range(1, 8) : 5;
            end
        end
    end

    // monitor: scoreboard pops, pin timing and frame totals
    initial begin : monitor
        int cyc, last_hi, last_rv_hi, last_wr, bp_at;
        int hi_len[4];
        int n_rise[4];
        logic [3:0] pins, pins_prev;
        logic busy_prev, start_prev, rst_prev, adc_prev, full_prev;
        bit first_pin;
        logic [7:0] e;
        cyc = 0; last_hi = -1000; last_rv_hi = -1000; last_wr = -1000; bp_at = -1;
        pins_prev = 0; busy_prev = 0; start_prev = 1; rst_prev = 0; adc_prev = 0;
        full_prev = 0; first_pin = 0;
        for (int i = 0; i < 4; i++) begin hi_len[i] = 0; n_rise[i] = 0; end
        forever begin
            @(negedge PCLK);
            cyc++;
            pins = {INCV, RESV, INCP, RESP};
            if (!PRESERN) begin
                exp_q.delete();
                pins_prev = 0; busy_prev = 0; start_prev = 1; rst_prev = 0;
                adc_prev = 0; full_prev = 0; bp_at = -1;
            end else begin
                if (rst_prev && !busy_prev)
                    chk(BUSY == !start_prev, "busy_accept", int'(BUSY), int'(!start_prev));
                if (pins != 0 || ADC_START || !FIFO_WREN || BUSY) act_cnt++;
                if (BUSY && !busy_prev) begin
                    n_wr = 0; n_adc = 0; first_pin = 0; last_hi = -1000; last_rv_hi = -1000;
                    for (int i = 0; i < 4; i++) begin hi_len[i] = 0; n_rise[i] = 0; end
                end
                if (pins != 0) chk($countones(pins) == 1, "pin_overlap", int'(pins), 1);
                for (int i = 0; i < 4; i++) begin
                    if (pins[i] && !pins_prev[i]) begin
                        n_rise[i]++;
                        hi_len[i] = 0;
                        if (!first_pin) begin
                            chk(i == 0, "first_pin_resp", i, 0);
                            first_pin = 1;
                        end else begin
                            chk(cyc - last_hi - 1 >= P, "pin_low_gap", cyc - last_hi - 1, P);
                        end
                    end
                    if (pins[i]) hi_len[i]++;
                    if (!pins[i] && pins_prev[i]) chk(hi_len[i] == P, "pin_high_len", hi_len[i], P);
                end
                if (pins != 0) last_hi = cyc;
                if (pins[2] || pins[3]) last_rv_hi = cyc;
                if (ADC_START) begin
                    n_adc++;
                    chk(!adc_prev, "adc_start_width", int'(adc_prev), 0);
                    chk(cyc - last_rv_hi == P + S + 1, "adc_start_timing", cyc - last_rv_hi, P + S + 1);
                end
                if (full_prev) chk(FIFO_WREN == 1'b1, "wren_during_full", int'(FIFO_WREN), 1);
                if (bp_at == cyc) begin
                    chk(!FIFO_WREN && FIFO_DATA == 8'h12, "bp_write_timing",
                        int'({FIFO_WREN, FIFO_DATA}), 'h012);
                    bp_done = 1;
                    bp_at = -1;
                end
                if (bp_mode && full_prev && !FIFO_FULL && BUSY) bp_at = cyc + 1;
                if (!FIFO_WREN) begin
                    n_wr++;
                    last_wr = cyc;
                    chk(BUSY, "busy_at_write", int'(BUSY), 1);
                    if (exp_q.size() == 0) begin
                        chk(0, "write_unexpected", int'(FIFO_DATA), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk(FIFO_DATA == e, "pixel", int'(FIFO_DATA), int'(e));
                    end
                end
                if (!BUSY && busy_prev) begin
                    chk(n_wr == R * C, "frame_writes", n_wr, R * C);
                    chk(last_wr == cyc - 1, "busy_drop", cyc - last_wr, 1);
                    chk(n_rise[0] == 2 * R, "resp_count", n_rise[0], 2 * R);
                    chk(n_rise[1] == R, "incp_count", n_rise[1], R);
                    chk(n_rise[2] == 2 * R, "resv_count", n_rise[2], 2 * R);
                    chk(n_rise[3] == R * (C - 1) + R * (R - 1) / 2, "incv_count",
                        n_rise[3], R * (C - 1) + R * (R - 1) / 2);
                    chk(n_adc == R * C, "adc_count", n_adc, R * C);
                    chk(exp_q.size() == 0, "samples_left", exp_q.size(), 0);
                    frames_done++;
                end
                pins_prev = pins; busy_prev = BUSY; start_prev = START_CAPTURE;
                rst_prev = 1; adc_prev = ADC_START; full_prev = FIFO_FULL;
            end
        end
    end

    task automatic strobe(input int len);
        START_CAPTURE = 0;
        tick(len);
        START_CAPTURE = 1;
    endtask

    task automatic do_reset();
        #2;
        PRESERN = 0;
        #1;
        chk(BUSY == 0, "rst_busy", int'(BUSY), 0);
        chk({RESP, INCP, RESV, INCV} == 4'b0, "rst_pins", int'({RESP, INCP, RESV, INCV}), 0);
        chk(ADC_START == 0, "rst_adc_start", int'(ADC_START), 0);
        chk(FIFO_WREN == 1, "rst_wren", int'(FIFO_WREN), 1);
        chk(FIFO_DATA == 0, "rst_data", int'(FIFO_DATA), 0);
        tick(3);
        PRESERN = 1;
        tick(1);
    endtask

    task automatic wait_frame();
        int f0;
        f0 = frames_done;
        for (int i = 0; i < 3000 && frames_done == f0; i++) tick(1);
        chk(frames_done != f0, "frame_timeout", frames_done, f0 + 1);
    endtask

    task automatic wait_count(input int which, input int target, input string name);
        int v;
        v = -1;
        for (int i = 0; i < 3000; i++) begin
            v = (which == 0) ? n_wr : n_adc;
            if (v == target) break;
            tick(1);
        end
        chk(v == target, name, v, target);
    endtask

    initial begin : stimulus
        int frames_exp, a0;
        frames_exp = 0;
        PRESERN = 0;
        START_CAPTURE = 1;
        tick(3);
        PRESERN = 1;
        tick(2);

        // reset mid-frame, then a long quiet idle
        strobe(1);
        tick(30);
        do_reset();
        a0 = act_cnt;
        tick(100);
        chk(act_cnt == a0, "idle_activity", act_cnt - a0, 0);

        // full fixed-data frame
        strobe(1);
        frames_exp++;
        wait_frame();

        // backpressure on the third sample
        bp_mode = 1;
        strobe(1);
        frames_exp++;
        wait_frame();
        bp_mode = 0;
        chk(bp_done, "bp_check_reached", int'(bp_done), 1);

        // strobe during the 4th pixel is ignored
        strobe(1);
        frames_exp++;
        wait_count(0, 3, "wait_3_writes");
        strobe(2);
        wait_frame();
        a0 = act_cnt;
        tick(50);
        chk(act_cnt == a0, "no_second_frame", act_cnt - a0, 0);

        // reset while waiting for the 2nd conversion, then a clean frame
        strobe(1);
        wait_count(1, 2, "wait_2_adc");
        tick(2);
        do_reset();
        strobe(1);
        frames_exp++;
        wait_frame();

        // randomized data, ADC latency and FIFO backpressure
        rand_data = 1;
        rand_full = 1;
        for (int k = 0; k < 4; k++) begin
            strobe($urandom_range(1, 2));
            frames_exp++;
            tick($urandom_range(5, 60));
            strobe($urandom_range(1, 2));
            wait_frame();
            tick($urandom_range(0, 3));
        end
        rand_full = 0;
        tick(5);
        chk(frames_done == frames_exp, "frame_count", frames_done, frames_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
